// File: rtl/display_scan_if.sv
// Scan-mux bus: capture/enable controls in, scan position and anode drive out.
interface display_scan_if #(
    parameter int DIGITS = 8,
    parameter int IW     = ($clog2(DIGITS) > 1) ? $clog2(DIGITS) : 1
);
    logic                  enable;
    logic [4*DIGITS-1:0]   data;
    logic                  load;
    logic                  busy;
    logic [IW-1:0]         digit_sel;
    logic [3:0]            nibble;
    logic [DIGITS-1:0]     anode;
    logic                  tick;

    modport master (output enable, data, load,
                    input  busy, digit_sel, nibble, anode, tick);
    modport slave  (input  enable, data, load,
                    output busy, digit_sel, nibble, anode, tick);
endinterface

// File: rtl/display_scan_mux.sv
// Multiplexed 7-seg digit scanner with frame-synchronous double buffering.
// Optional leading-zero blanking is built when DISPLAY_SCAN_LZB_EN is defined.
module display_scan_mux #(
    parameter int DIGITS = 8,
    parameter int DIV    = 100000
) (
    input  logic          clock,
    input  logic          reset,
    display_scan_if.slave bus
);
    localparam int IW = ($clog2(DIGITS) > 1) ? $clog2(DIGITS) : 1;
    localparam int PW = $clog2(DIV);

    logic [PW-1:0]            presc;
    logic [IW-1:0]            idx;
    logic [DIGITS-1:0][3:0]   shadow;
    logic [DIGITS-1:0][3:0]   pending;
    logic                     busy_q;
    logic                     tick;
    logic                     wrap;
    logic [DIGITS-1:0]        onehot;

    assign tick = bus.enable && (presc == PW'(DIV - 1));
    assign wrap = tick && (idx == IW'(DIGITS - 1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            presc   <= '0;
            idx     <= '0;
            shadow  <= '0;
            pending <= '0;
            busy_q  <= 1'b0;
        end else begin
            if (bus.enable)
                presc <= tick ? '0 : presc + 1'b1;
            if (tick)
                idx <= wrap ? '0 : idx + 1'b1;
            // Shadow only moves on the frame wrap, so a frame never mixes old and new digits.
            if (wrap && busy_q)
                shadow <= pending;
            if (bus.load)
                pending <= bus.data;
            if (bus.load)
                busy_q <= 1'b1;
            else if (wrap)
                busy_q <= 1'b0;
        end
    end

    always_comb begin
        onehot      = '0;
        onehot[idx] = 1'b1;
    end

`ifdef DISPLAY_SCAN_LZB_EN
    // zero_above[k]: digit k and every digit above it are zero.
    logic [DIGITS:0] zero_above;
    logic            blank;

    assign zero_above[DIGITS] = 1'b1;
    for (genvar k = 0; k < DIGITS; k++) begin : g_lz
        assign zero_above[k] = (shadow[k] == 4'h0) && zero_above[k+1];
    end
    assign blank     = (idx != '0) && zero_above[idx];
    assign bus.anode = (bus.enable && !blank) ? ~onehot : '1;
`else
    assign bus.anode = bus.enable ? ~onehot : '1;
`endif

    assign bus.busy      = busy_q;
    assign bus.digit_sel = idx;
    assign bus.nibble    = shadow[idx];
    assign bus.tick      = tick;
endmodule

// File: doc/display_scan_mux.md
DISPLAY_SCAN_MUX -- requirements
Module: display_scan_mux

Interface
- REQ-001 The block SHALL have parameter DIGITS, default 8, giving the number of 4-bit digits scanned (legal range 2..16).
- REQ-002 The block SHALL have parameter DIV, default 100000, giving the clock cycles per digit slot (legal range 2..2^24).
- REQ-003 The block SHALL define IW = max(1, clog2(DIGITS)) as the digit index width.
- REQ-004 Port clock: input, 1 bit, the single clock; all state is rising-edge triggered.
- REQ-005 Port reset: input, 1 bit, asynchronous, active-low reset (asserted when 0).
- REQ-006 Port enable: input, 1 bit; high = scan running; low = prescaler frozen and display blanked.
- REQ-007 Port data: input, 4*DIGITS bits; digit k is data[4k+3:4k].
- REQ-008 Port load: input, 1 bit, single-cycle strobe that captures data.
- REQ-009 Port busy: output, 1 bit; high while captured data is waiting for a frame boundary.
- REQ-010 Port digit_sel: output, IW bits, current digit index.
- REQ-011 Port nibble: output, 4 bits, the displayed digit value.
- REQ-012 Port anode: output, DIGITS bits, active-low one-hot digit enable.
- REQ-013 Port tick: output, 1 bit, one-cycle pulse on each digit advance.

Function
- REQ-014 The prescaler SHALL count 0..DIV-1 while enable=1 and SHALL hold its value while enable=0.
- REQ-015 tick SHALL be high in exactly the cycles where prescaler==DIV-1 and enable=1; the prescaler SHALL then wrap to 0.
- REQ-016 On each tick the index SHALL advance by 1, wrapping from DIGITS-1 to 0 (frame boundary), including non-power-of-2 DIGITS.
- REQ-017 A load=1 cycle SHALL capture data into a pending register and set busy on the next edge; a later load before the boundary SHALL overwrite pending.
- REQ-018 At a frame-boundary tick with busy=1, the display shadow register SHALL take pending and busy SHALL clear, unless load=1 in that same cycle.
- REQ-019 If load=1 coincides with a frame-boundary tick, the shadow SHALL take the old pending contents (if busy=1) and pending SHALL take the new data, with busy remaining or becoming 1.
- REQ-020 With busy=0 at a boundary, the shadow SHALL remain unchanged.
- REQ-021 digit_sel SHALL equal the registered index; nibble SHALL equal shadow digit[index], zero latency from the registers.
- REQ-022 anode SHALL be all ones when enable=0; otherwise it SHALL be all ones except bit[index]=0.
- REQ-023 The shadow SHALL never change mid-frame, so a frame never shows mixed old and new data.

Reset
- REQ-024 While reset=0, prescaler=0, index=0, shadow=0, pending=0 and busy=0, regardless of clock.
- REQ-025 Immediately after reset, outputs SHALL be digit_sel=0, nibble=0 and tick=0, with anode=~1 if enable=1 and all ones otherwise.
- REQ-026 Reset asserted mid-frame SHALL discard pending data and SHALL restart the scan at digit 0 on release.

Configuration
- REQ-027 With macro DISPLAY_SCAN_LZB_EN defined, leading-zero blanking SHALL be built in: a digit k>0 whose shadow value is 0, with all digits above k also 0, SHALL have anode forced to all ones during its slot, and digit 0 SHALL never be blanked.
- REQ-028 Without DISPLAY_SCAN_LZB_EN, no blanking logic SHALL exist and all digits SHALL be shown per REQ-022.
- REQ-029 Index, tick and timing SHALL be identical with and without DISPLAY_SCAN_LZB_EN.

Verification (DIGITS=8, DIV=4)
- REQ-030 Reset release with enable=1: tick every 4th cycle; digit_sel steps 0..7,0; anode steps FE, FD, ... 7F, FE.
- REQ-031 Load 0x87654321 mid-frame: busy=1 until the 7->0 tick; nibble then reads 1,2,...,8 over the next frame; the old frame is unaltered.
- REQ-032 Load coinciding with a boundary tick while busy=1: shadow takes the old pending value; the new value appears one frame later; busy stays 1 throughout.
- REQ-033 enable=0 for 10 cycles at digit 3: anode=FF, digit_sel holds 3, tick=0, and the prescaler resumes from its held count.
- REQ-034 DISPLAY_SCAN_LZB_EN defined, shadow 0x00000120: anode=FF in slots 3..7; slots 0..2 show 0,2,1; shadow 0 shows digit 0 only.
- REQ-035 Reset pulse mid-frame with busy=1: busy=0, digit_sel=0, nibble=0 immediately; scan restarts at digit 0.
